efi_out_scheduler: RTL and testbench
====================================

Name: efi_out_scheduler

Overview:
- Parametrised angle-triggered output scheduler for ignition coils and injectors; successor to the fixed 8-output ignition stage inside efi_main.
- Per channel: start angle plus on-duration in clk ticks, double-buffered (shadow/active) so the MCU can update mid-cycle without tearing.
- Sits between the crank position decoder (phase, phase_stb, synced) and the GPIO output pins; clocked by clk_efi (2 MHz).

Parameters:
- CHANNELS, 8, number of output channels (1..32).
- PHASE_W, 12, width of the engine angle counter.
- DUR_W, 16, width of the per-channel duration in clk cycles.
- MAX_ON, 20000, on-time clamp in clk cycles (10 ms at 2 MHz); must fit in DUR_W.
- OUT_POL, 1, active level of out (1 = active-high).

Ports:
- clk  in  1  scheduler clock (clk_efi domain).
- reset_n  in  1  reset.
- synced  in  1  crank decoder has position lock.
- phase  in  PHASE_W  current engine angle; valid when phase_stb is high.
- phase_stb  in  1  one-cycle pulse when phase takes a new value.
- wr_en  in  1  channel configuration write strobe.
- wr_ch  in  CH_W  channel index; CH_W = max(1, clog2(CHANNELS)).
- wr_start  in  PHASE_W  start angle to write.
- wr_dur  in  DUR_W  duration to write; 0 disables the channel.
- out  out  CHANNELS  driven outputs, polarity per OUT_POL.
- busy  out  CHANNELS  raw per-channel on state, active-high regardless of OUT_POL.
- cycle_start  out  1  one-cycle pulse after each shadow-to-active transfer.
- wr_err  out  1  one-cycle pulse on a write to an out-of-range channel.
- overrun  out  CHANNELS  sticky retrigger flags; only present with EFI_SCHED_OVERRUN_EN.

Behaviour:
- Single clock. Reset is synchronous and active-low: reset_n is sampled on the rising edge of clk.
- Reset values:
  - Shadow and active start/dur are all 0.
  - busy = 0, timers = 0.
  - out = all bits at ~OUT_POL.
  - cycle_start = 0, wr_err = 0, overrun = 0.
- Reset mid-pulse: outputs go inactive at that edge.
- Writes:
  - wr_en with wr_ch < CHANNELS loads shadow[wr_ch] at the edge. A later write to the same channel overwrites it.
  - wr_en with wr_ch >= CHANNELS changes no state and raises wr_err for the following cycle only.
- Transfer:
  - Occurs on an edge where synced & phase_stb & (phase == 0): active <= shadow for all channels simultaneously.
  - cycle_start is high for the cycle after that edge.
  - A write on the transfer edge lands in shadow only; active receives the pre-write shadow value.
- Trigger:
  - Occurs on an edge where synced & phase_stb, for each channel with the next-active dur != 0 and phase == next-active start.
  - Next-active means the post-transfer values, so start = 0 fires on the transfer edge using the new config.
  - On trigger, timer <= min(dur, MAX_ON) and busy <= 1.
- Pulse:
  - busy is high for exactly min(dur, MAX_ON) cycles, starting the cycle after the trigger edge.
  - The timer decrements each cycle; busy clears on the edge where the timer reaches 0.
  - out[i] = busy[i] ? OUT_POL : ~OUT_POL, registered with busy (no extra latency).
- Retrigger while busy:
  - Default: the timer reloads with the fresh duration and out stays asserted continuously, with no glitch.
  - With EFI_SCHED_OVERRUN_EN: see Optional Feature.
- Loss of sync:
  - synced low clears all busy and timers at the next edge.
  - phase_stb is ignored while synced is low.
  - Shadow and active registers are retained; writes are still accepted.
- phase_stb high with no matching channel has no effect.
- Multiple channels may trigger on the same edge.

Optional Feature:
- Macro: EFI_SCHED_OVERRUN_EN.
- Defined:
  - A trigger on a channel that is already busy is ignored; the timer continues.
  - overrun[i] is set and stays set until reset or a valid write to channel i.
  - If a write and an overrun hit the same channel on the same edge, set wins.
- Undefined:
  - The overrun port and its logic are absent.
  - Retrigger reloads the timer as described in Behaviour.

Test Plan:
- Reset/idle: OUT_POL=1; reset_n low 2 cycles -> out=0x00, busy=0, cycle_start=0. Then synced=1 and phase_stb at phase=100 with all dur=0 -> out stays 0x00.
- Basic fire: write ch3 start=40 dur=5; phase_stb at phase=0 (transfer) -> cycle_start pulse. phase_stb at phase=40 -> out[3] high for exactly 5 cycles starting the next cycle; other bits stay 0.
- Clamp and boundary:
  - MAX_ON=20: ch0 start=0 dur=1000 -> busy[0] high 20 cycles.
  - A write of ch0 start=0 dur=3 on the transfer edge -> this cycle still fires 20 cycles; the next revolution fires 3.
- Sync loss: ch1 dur=50 firing; synced drops at cycle 10 of the pulse -> out[1] low next cycle. phase_stb at phase=start while unsynced -> no fire.
- Retrigger: ch2 dur=10; second matching strobe 4 cycles into the pulse.
  - Default -> 14 continuous cycles high.
  - With EFI_SCHED_OVERRUN_EN -> 10 cycles and overrun[2]=1 until a write to ch2.
- Errors/polarity: CHANNELS=6, write wr_ch=7 -> wr_err one cycle and no shadow change. OUT_POL=0 -> idle out=0x3F; a firing channel reads 0.

Source files
------------

// File: rtl/efi_out_scheduler.sv
// Angle-triggered output scheduler: double-buffered start/duration per channel, fires on phase match.
// Optional EFI_SCHED_OVERRUN_EN: ignore retriggers while busy and raise sticky per-channel overrun flags.
module efi_out_scheduler #(
    parameter int  CHANNELS = 8,
    parameter int  PHASE_W  = 12,
    parameter int  DUR_W    = 16,
    parameter int  MAX_ON   = 20000,
    parameter bit  OUT_POL  = 1'b1,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                synced,
    input  logic [PHASE_W-1:0]  phase,
    input  logic                phase_stb,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [PHASE_W-1:0]  wr_start,
    input  logic [DUR_W-1:0]    wr_dur,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] busy,
    output logic                cycle_start,
    output logic                wr_err
`ifdef EFI_SCHED_OVERRUN_EN
    ,
    output logic [CHANNELS-1:0] overrun
`endif
);

    localparam logic [DUR_W-1:0] MAX_ON_D = DUR_W'(MAX_ON);

    logic [PHASE_W-1:0]  r_sh_start  [CHANNELS];
    logic [DUR_W-1:0]    r_sh_dur    [CHANNELS];
    logic [PHASE_W-1:0]  r_act_start [CHANNELS];
    logic [DUR_W-1:0]    r_act_dur   [CHANNELS];
    logic [DUR_W-1:0]    r_timer     [CHANNELS];
    logic [CHANNELS-1:0] r_busy;
    logic [CHANNELS-1:0] r_out;
    logic                r_cycle_start;
    logic                r_wr_err;

    logic                w_xfer;
    logic                w_ch_ok;
    logic [PHASE_W-1:0]  w_na_start [CHANNELS];
    logic [DUR_W-1:0]    w_na_dur   [CHANNELS];
    logic [DUR_W-1:0]    w_load     [CHANNELS];
    logic [CHANNELS-1:0] w_trig;
    logic [CHANNELS-1:0] w_fire;
    logic [CHANNELS-1:0] w_wr_hit;

    // Trigger decisions use the post-transfer ("next-active") config so start=0 fires on the transfer edge.
    always_comb begin
        w_xfer  = synced & phase_stb & (phase == '0);
        w_ch_ok = (32'(wr_ch) < 32'(CHANNELS));
        for (int i = 0; i < CHANNELS; i++) begin
            w_na_start[i] = w_xfer ? r_sh_start[i] : r_act_start[i];
            w_na_dur[i]   = w_xfer ? r_sh_dur[i]   : r_act_dur[i];
            w_load[i]     = (w_na_dur[i] > MAX_ON_D) ? MAX_ON_D : w_na_dur[i];
            w_trig[i]     = synced & phase_stb & (w_na_dur[i] != '0) & (phase == w_na_start[i]);
            w_wr_hit[i]   = wr_en & w_ch_ok & (wr_ch == CH_W'(i));
        end
`ifdef EFI_SCHED_OVERRUN_EN
        w_fire = w_trig & ~r_busy;
`else
        w_fire = w_trig;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_sh_start[i]  <= '0;
                r_sh_dur[i]    <= '0;
                r_act_start[i] <= '0;
                r_act_dur[i]   <= '0;
                r_timer[i]     <= '0;
            end
            r_busy        <= '0;
            r_out         <= {CHANNELS{~OUT_POL}};
            r_cycle_start <= 1'b0;
            r_wr_err      <= 1'b0;
        end else begin
            r_cycle_start <= w_xfer;
            r_wr_err      <= wr_en & ~w_ch_ok;
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_wr_hit[i]) begin
                    r_sh_start[i] <= wr_start;
                    r_sh_dur[i]   <= wr_dur;
                end
                // Non-blocking copy means a write on the transfer edge stays in shadow only.
                if (w_xfer) begin
                    r_act_start[i] <= r_sh_start[i];
                    r_act_dur[i]   <= r_sh_dur[i];
                end
                if (!synced) begin
                    r_timer[i] <= '0;
                    r_busy[i]  <= 1'b0;
                    r_out[i]   <= ~OUT_POL;
                end else if (w_fire[i]) begin
                    r_timer[i] <= w_load[i];
                    r_busy[i]  <= 1'b1;
                    r_out[i]   <= OUT_POL;
                end else if (r_busy[i]) begin
                    r_timer[i] <= r_timer[i] - DUR_W'(1);
                    r_busy[i]  <= (r_timer[i] > DUR_W'(1));
                    r_out[i]   <= (r_timer[i] > DUR_W'(1)) ? OUT_POL : ~OUT_POL;
                end
            end
        end
    end

`ifdef EFI_SCHED_OVERRUN_EN
    logic [CHANNELS-1:0] r_overrun;

    // A retrigger on the same edge as a clearing write keeps the flag set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overrun <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_trig[i] && r_busy[i]) begin
                    r_overrun[i] <= 1'b1;
                end else if (w_wr_hit[i]) begin
                    r_overrun[i] <= 1'b0;
                end
            end
        end
    end

    assign overrun = r_overrun;
`endif

    assign out         = r_out;
    assign busy        = r_busy;
    assign cycle_start = r_cycle_start;
    assign wr_err      = r_wr_err;

endmodule

// File: tb/tb_efi_out_scheduler.sv
// Scoreboard bench for efi_out_scheduler: directed scenarios then random traffic vs a cycle reference model.
module tb_efi_out_scheduler;

    localparam int CH  = 6;
    localparam int PW  = 8;
    localparam int DW  = 16;
    localparam int MX  = 20;
    localparam bit POL = 1'b0;
    localparam int CHW = 3;
    localparam int EW  = 3 * CH + 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          synced = 1'b0;
    logic [PW-1:0] phase = '0;
    logic          phase_stb = 1'b0;
    logic          wr_en = 1'b0;
    logic [CHW-1:0] wr_ch = '0;
    logic [PW-1:0] wr_start = '0;
    logic [DW-1:0] wr_dur = '0;
    logic [CH-1:0] out;
    logic [CH-1:0] busy;
    logic          cycle_start;
    logic          wr_err;
`ifdef EFI_SCHED_OVERRUN_EN
    logic [CH-1:0] overrun;
`endif

    always #5 clk = ~clk;

    efi_out_scheduler #(
        .CHANNELS(CH), .PHASE_W(PW), .DUR_W(DW), .MAX_ON(MX), .OUT_POL(POL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .synced(synced), .phase(phase), .phase_stb(phase_stb),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_start(wr_start), .wr_dur(wr_dur),
        .out(out), .busy(busy), .cycle_start(cycle_start), .wr_err(wr_err)
`ifdef EFI_SCHED_OVERRUN_EN
        , .overrun(overrun)
`endif
    );

    // Reference model: configured angles/durations and remaining on-cycles per channel.
    int m_sh_start[CH], m_sh_dur[CH], m_act_start[CH], m_act_dur[CH], m_rem[CH];
    bit m_ovr[CH];

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [EW-1:0] pk(logic [CH-1:0] o, logic [CH-1:0] b, logic [CH-1:0] u,
                                         logic c, logic w);
        return {o, b, u, c, w};
    endfunction

    task automatic model_step();
        logic [CH-1:0] eo, eb, eu;
        bit xfer, werr;
        int na_s[CH], na_d[CH];
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                m_sh_start[i] = 0; m_sh_dur[i] = 0; m_act_start[i] = 0; m_act_dur[i] = 0;
                m_rem[i] = 0; m_ovr[i] = 1'b0;
            end
            exp_q.push_back(pk('0, '0, {CH{~POL}}, 1'b0, 1'b0));
            return;
        end
        xfer = synced && phase_stb && (phase == 0);
        werr = wr_en && (int'(wr_ch) >= CH);
        for (int i = 0; i < CH; i++) begin
            na_s[i] = xfer ? m_sh_start[i] : m_act_start[i];
            na_d[i] = xfer ? m_sh_dur[i]   : m_act_dur[i];
        end
        if (wr_en && int'(wr_ch) < CH) begin
            m_sh_start[wr_ch] = int'(wr_start);
            m_sh_dur[wr_ch]   = int'(wr_dur);
            m_ovr[wr_ch]      = 1'b0;
        end
        for (int i = 0; i < CH; i++) begin
            m_act_start[i] = na_s[i];
            m_act_dur[i]   = na_d[i];
            if (!synced) begin
                m_rem[i] = 0;
            end else if (phase_stb && na_d[i] != 0 && int'(phase) == na_s[i]) begin
`ifdef EFI_SCHED_OVERRUN_EN
                if (m_rem[i] > 0) begin
                    m_ovr[i] = 1'b1;
                    m_rem[i] = m_rem[i] - 1;
                end else begin
                    m_rem[i] = (na_d[i] > MX) ? MX : na_d[i];
                end
`else
                m_rem[i] = (na_d[i] > MX) ? MX : na_d[i];
`endif
            end else if (m_rem[i] > 0) begin
                m_rem[i] = m_rem[i] - 1;
            end
        end
        for (int i = 0; i < CH; i++) begin
            eb[i] = (m_rem[i] > 0);
            eu[i] = eb[i] ? POL : ~POL;
            eo[i] = m_ovr[i];
        end
        exp_q.push_back(pk(eo, eb, eu, xfer, werr));
    endtask

    // Monitor: compares the DUT state after each edge against the oldest expectation.
    always @(negedge clk) begin
        logic [EW-1:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
`ifdef EFI_SCHED_OVERRUN_EN
            a = pk(overrun, busy, out, cycle_start, wr_err);
`else
            a = pk('0, busy, out, cycle_start, wr_err);
`endif
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL sb_edge check %0d t=%0t: got {ovr,busy,out,cs,werr}=%h, required %h",
                          n_checks, $time, a, e);
        end
    end

    task automatic drv(input bit rn, input bit sy, input int ph, input bit st,
                       input bit we, input int wc, input int ws, input int wd);
        @(negedge clk);
        #1;
        reset_n   = rn;
        synced    = sy;
        phase     = PW'(ph);
        phase_stb = st;
        wr_en     = we;
        wr_ch     = CHW'(wc);
        wr_start  = PW'(ws);
        wr_dur    = DW'(wd);
        model_step();
    endtask

    task automatic idle(input int n, input bit sy = 1'b1);
        for (int k = 0; k < n; k++) drv(1'b1, sy, 0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic strobe(input int ph, input bit sy = 1'b1);
        drv(1'b1, sy, ph, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic write(input int ch, input int s, input int d);
        drv(1'b1, 1'b1, 0, 1'b0, 1'b1, ch, s, d);
    endtask

    initial begin
        // Reset and idle: no channel configured, a strobe does nothing.
        drv(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        drv(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        idle(1);
        strobe(100);
        idle(2);
        // Basic fire on ch3.
        write(3, 40, 5);
        strobe(0);
        idle(2);
        strobe(40);
        idle(8);
        // Clamp, then a write landing on the transfer edge.
        write(0, 0, 1000);
        strobe(0);
        idle(24);
        drv(1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 0, 3);
        idle(24);
        strobe(0);
        idle(6);
        // Loss of sync mid-pulse, strobe ignored while unsynced.
        write(1, 10, 50);
        strobe(0);
        strobe(10);
        idle(9);
        idle(3, 1'b0);
        strobe(10, 1'b0);
        idle(2, 1'b0);
        idle(2);
        // Retrigger 4 cycles into a pulse, then a write to the same channel.
        write(2, 20, 10);
        strobe(0);
        strobe(20);
        idle(3);
        strobe(20);
        idle(16);
        write(2, 20, 10);
        idle(2);
        // Out-of-range write: error pulse, nothing stored.
        drv(1'b1, 1'b1, 0, 1'b0, 1'b1, 7, 33, 44);
        idle(1);
        strobe(0);
        strobe(33);
        idle(3);
        // Randomised traffic over a small angle range so matches and transfers are frequent.
        for (int k = 0; k < 3000; k++) begin
            drv($urandom_range(0, 199) != 0, $urandom_range(0, 19) != 0,
                $urandom_range(0, 15), $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7), $urandom_range(0, 15),
                ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30));
        end
        idle(1);
        @(negedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL sb_drain: got %0d pending, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
